regfile_writeback_arbiter: RTL and testbench
============================================

# regfile_writeback_arbiter

Writeback front-end for the 16x16 register file: collects write requests from the ALU and the load/memory path, buffers each source in a small FIFO, and arbitrates them onto the register file's single write port. Outputs are registered, one write per cycle. It also reports pending writes to the issue stage for hazard detection. It sits between the execute/memory stages and the register file's write_addr / write_data / write_enable inputs.

## Interface
- DATA_W, 16, data width; matches the register file word.
- ADDR_W, 4, register address width (16 registers).
- DEPTH, 2, entries per source FIFO, power of two, ≥2.
- STARVE_MAX, 3, consecutive lost ALU arbitrations before the ALU is forced to win.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load write request.
- mem_ready  out  1  memory FIFO can accept.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- wb_en  out  1  drives the register file write_enable.
- wb_addr  out  ADDR_W  drives write_addr.
- wb_data  out  DATA_W  drives write_data.
- chk_addr1  in  ADDR_W  issue-stage source register 1.
- chk_addr2  in  ADDR_W  issue-stage source register 2.
- pend1  out  1  a write to chk_addr1 is queued or in flight.
- pend2  out  1  a write to chk_addr2 is queued or in flight.

## Operation
- Push: on a posedge with s_valid && s_ready, {addr,data} is written at the tail of source s. s_ready = !rst && count_s < DEPTH. It uses count at cycle start only, so there is no combinational path from arbitration to ready. A full FIFO popping this cycle still shows ready low.
- Per-source order is strictly FIFO. Cross-source order is arbitration order only. Preventing same-address WAW races across sources is upstream's job, using pend1/pend2.
- Arbitration at each posedge, among non-empty FIFOs:
  - If both are non-empty, mem wins, unless starve_cnt == STARVE_MAX, in which case alu wins.
  - If only one is non-empty, it wins.
  - If both are empty, there is no grant.
- Starvation counter starve_cnt, range 0..STARVE_MAX:
  - Increments when alu is non-empty and mem wins.
  - Clears on an alu grant or when the alu FIFO is empty.
  - Saturates; it never wraps.
- Grant pops the head. The next wb_en/wb_addr/wb_data registers take the head's contents. With no grant, wb_en=0 and wb_addr/wb_data hold their previous values.
- Simultaneous push and pop on the same FIFO in one cycle is legal. Count is unchanged and pointers wrap modulo DEPTH.
- pend1/pend2 are combinational. pendN=1 if either of these matches chk_addrN:
  - any valid entry in either FIFO;
  - the current wb_addr while wb_en=1.
- Reset mid-operation: all queued entries are discarded and none are written.

## Timing
- Reset values:
  - Registers: wb_en=0, wb_addr=0, wb_data=0, both FIFOs empty, starve_cnt=0.
  - Outputs during and after rst: alu_ready=0 and mem_ready=0 while rst is high; pend1=pend2=0 after reset.
- Latency, with the arbiter idle:
  - Request accepted at edge N.
  - Entry shows on wb_* after edge N+1.
  - Register file captures it at edge N+2.
- Throughput: one write per cycle sustained. Each source sustains one push per cycle if only it is active and DEPTH ≥ 2.
- Hazard window: pendN stays high until the edge at which the register file captures the write. From the next cycle, the combinational register-file read returns the new value.

## Structure
- Shared package regfile_pkg:
  - DATA_W and ADDR_W defaults, also used by the register file;
  - wb_req_t struct {addr, data}.
- Sub-module wb_fifo: parameterised DEPTH × wb_req_t synchronous FIFO.
  - Instantiated twice.
  - Exposes count, head, and an entry-valid/address vector for the pending compare.
- The top level holds the arbiter, starve_cnt, the output registers, and the pending comparators.

## Test plan
- Single ALU write: alu {addr=3, data=16'hBEEF} at edge 0 -> wb_en=1, wb_addr=3, wb_data=BEEF in the cycle after edge 1 only; pend1 (chk_addr1=3) high from after edge 0 until edge 2.
- Collision: both sources push every cycle, alu addr 1..8 and mem addr 9..15, STARVE_MAX=3 -> grant pattern mem,mem,mem,alu repeating; each source's addresses emerge in push order.
- Backpressure: hold wb path busy with mem traffic and push 3 ALU requests with DEPTH=2 -> alu_ready drops after the 2nd accept; the 3rd is accepted only once count<2; no loss or duplication.
- Wrap-around: 10 back-to-back pushes on mem alone -> 10 writes in order, one per cycle, pointers wrap correctly, mem_ready stays high.
- Reset mid-operation: both FIFOs full, assert rst for one cycle -> wb_en=0 and readys low during rst; after release no queued write ever appears, pend1/pend2=0.
- Pending detection: chk_addr2=5 with a queued mem write to 5 and an in-flight wb to 7 -> pend2=1; change chk_addr2 to 7 -> pend2=1; change it to 6 -> pend2=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: word/address widths, the writeback request
// record and the arbiter grant encoding.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MEM
  } grant_e;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Request, writeback and hazard-check signals between the execute/memory stages,
// the writeback arbiter and the register file.
interface regfile_writeback_arbiter_if;

  logic                          alu_valid;
  logic                          alu_ready;
  logic [regfile_pkg::ADDR_W-1:0] alu_addr;
  logic [regfile_pkg::DATA_W-1:0] alu_data;
  logic                          mem_valid;
  logic                          mem_ready;
  logic [regfile_pkg::ADDR_W-1:0] mem_addr;
  logic [regfile_pkg::DATA_W-1:0] mem_data;
  logic                          wb_en;
  logic [regfile_pkg::ADDR_W-1:0] wb_addr;
  logic [regfile_pkg::DATA_W-1:0] wb_data;
  logic [regfile_pkg::ADDR_W-1:0] chk_addr1;
  logic [regfile_pkg::ADDR_W-1:0] chk_addr2;
  logic                          pend1;
  logic                          pend2;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           chk_addr1, chk_addr2,
    input  alu_ready, mem_ready, wb_en, wb_addr, wb_data, pend1, pend2
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           chk_addr1, chk_addr2,
    output alu_ready, mem_ready, wb_en, wb_addr, wb_data, pend1, pend2
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; exposes occupancy, head and
// per-slot valid/address so the owner can run hazard compares over queued entries.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  wb_req_t                       i_req,
  input  logic                          i_pop,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output wb_req_t                       o_head,
  output logic [DEPTH-1:0]              o_slot_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  o_slot_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_req_t              r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_vld;

  // NOTE: the storage array is deliberately not reset; r_vld and r_count alone
  // decide which slots hold live entries, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_req;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_slot_addr[i] = r_mem[i].addr;
  end

  assign o_count    = r_count;
  assign o_head     = r_mem[r_rd_ptr];
  assign o_slot_vld = r_vld;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port, with
// mem priority bounded by an ALU starvation counter and combinational hazard flags.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_writeback_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = $clog2(STARVE_MAX+1);

  logic [CNT_W-1:0]             w_alu_count, w_mem_count;
  wb_req_t                      w_alu_head, w_mem_head, w_win;
  logic [DEPTH-1:0]             w_alu_vld, w_mem_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] w_alu_slot, w_mem_slot;
  logic                         w_alu_ready, w_mem_ready;
  logic                         w_alu_ne, w_mem_ne;
  grant_e                       w_grant;
  logic [STV_W-1:0]             w_starve_nxt;
  logic                         w_pend1, w_pend2;

  logic [STV_W-1:0]             r_starve;
  logic                         r_wb_en;
  logic [ADDR_W-1:0]            r_wb_addr;
  logic [DATA_W-1:0]            r_wb_data;

  // Ready looks only at start-of-cycle occupancy, never at this cycle's pop.
  assign w_alu_ready = !rst && (w_alu_count < CNT_W'(DEPTH));
  assign w_mem_ready = !rst && (w_mem_count < CNT_W'(DEPTH));
  assign w_alu_ne    = (w_alu_count != '0);
  assign w_mem_ne    = (w_mem_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (bus.alu_valid && w_alu_ready),
    .i_req       ('{addr: bus.alu_addr, data: bus.alu_data}),
    .i_pop       (w_grant == GNT_ALU),
    .o_count     (w_alu_count),
    .o_head      (w_alu_head),
    .o_slot_vld  (w_alu_vld),
    .o_slot_addr (w_alu_slot)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (bus.mem_valid && w_mem_ready),
    .i_req       ('{addr: bus.mem_addr, data: bus.mem_data}),
    .i_pop       (w_grant == GNT_MEM),
    .o_count     (w_mem_count),
    .o_head      (w_mem_head),
    .o_slot_vld  (w_mem_vld),
    .o_slot_addr (w_mem_slot)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_grant      = GNT_NONE;
    w_starve_nxt = r_starve;
    if (w_alu_ne && w_mem_ne)
      w_grant = (r_starve == STV_W'(STARVE_MAX)) ? GNT_ALU : GNT_MEM;
    else if (w_alu_ne)
      w_grant = GNT_ALU;
    else if (w_mem_ne)
      w_grant = GNT_MEM;

    if (!w_alu_ne || w_grant == GNT_ALU)
      w_starve_nxt = '0;
    else if (w_grant == GNT_MEM && r_starve != STV_W'(STARVE_MAX))
      w_starve_nxt = r_starve + STV_W'(1);
  end

  assign w_win = (w_grant == GNT_ALU) ? w_alu_head : w_mem_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve  <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      r_wb_en  <= (w_grant != GNT_NONE);
      if (w_grant != GNT_NONE) begin
        r_wb_addr <= w_win.addr;
        r_wb_data <= w_win.data;
      end
    end
  end

  // A write stays pending until the register file captures it off wb_*.
  always_comb begin
    w_pend1 = r_wb_en && (r_wb_addr == bus.chk_addr1);
    w_pend2 = r_wb_en && (r_wb_addr == bus.chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_vld[i] && w_alu_slot[i] == bus.chk_addr1) w_pend1 = 1'b1;
      if (w_mem_vld[i] && w_mem_slot[i] == bus.chk_addr1) w_pend1 = 1'b1;
      if (w_alu_vld[i] && w_alu_slot[i] == bus.chk_addr2) w_pend2 = 1'b1;
      if (w_mem_vld[i] && w_mem_slot[i] == bus.chk_addr2) w_pend2 = 1'b1;
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.wb_en     = r_wb_en;
  assign bus.wb_addr   = r_wb_addr;
  assign bus.wb_data   = r_wb_data;
  assign bus.pend1     = w_pend1;
  assign bus.pend2     = w_pend2;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: reset, latency, arbitration and
// starvation, backpressure, pointer wrap, mid-operation reset and hazard flags.
module tb_regfile_writeback_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  regfile_writeback_arbiter_if bus();

  regfile_writeback_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Writeback log filled by run_stream.
  logic [ADDR_W-1:0] log_addr [32];
  logic [DATA_W-1:0] log_data [32];
  int   n_log;
  int   first_cyc, last_cyc;
  logic alu_rdy_after2;
  logic mem_rdy_always;

  // Hand-derived grant orders (mem wins three times, then the starved ALU).
  int exp_coll [16] = '{9, 10, 11, 1, 12, 13, 14, 2, 15, 3, 4, 5, 6, 7, 8, 0};
  int exp_bp   [16] = '{10, 11, 12, 1, 13, 14, 15, 2, 3, 0, 0, 0, 0, 0, 0, 0};
  int exp_wrap [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers n_alu ALU and n_mem load requests back-to-back, honouring ready, and
  // logs every writeback until n_want are seen or the cycle budget runs out.
  task automatic run_stream(input int n_alu, input int a_base, input int n_mem,
                            input int m_base, input int n_want, input int budget);
    int   ai, mi;
    logic a_acc, m_acc;
    ai = 0; mi = 0; n_log = 0; first_cyc = -1; last_cyc = -1;
    alu_rdy_after2 = 1'b1; mem_rdy_always = 1'b1;
    for (int c = 0; c < budget && n_log < n_want; c++) begin
      bus.alu_valid = (ai < n_alu);
      bus.alu_addr  = ADDR_W'(a_base + ai);
      bus.alu_data  = DATA_W'(32'h1000 + a_base + ai);
      bus.mem_valid = (mi < n_mem);
      bus.mem_addr  = ADDR_W'(m_base + mi);
      bus.mem_data  = DATA_W'(32'h2000 + m_base + mi);
      if (mi < n_mem && !bus.mem_ready) mem_rdy_always = 1'b0;
      a_acc = bus.alu_valid && bus.alu_ready;
      m_acc = bus.mem_valid && bus.mem_ready;
      tick();
      if (a_acc) begin
        ai++;
        if (ai == 2) alu_rdy_after2 = bus.alu_ready;
      end
      if (m_acc) mi++;
      if (bus.wb_en) begin
        if (n_log < 32) begin
          log_addr[n_log] = bus.wb_addr;
          log_data[n_log] = bus.wb_data;
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        n_log++;
      end
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n_exp, input int exp_a [16],
                           input int alu_max);
    check({tag, "_count"}, n_log, n_exp);
    for (int i = 0; i < n_exp && i < n_log; i++) begin
      logic [DATA_W-1:0] d;
      d = (exp_a[i] <= alu_max) ? DATA_W'(32'h1000 + exp_a[i]) : DATA_W'(32'h2000 + exp_a[i]);
      check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(exp_a[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), 32'(d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_wb;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.chk_addr1 = '0;   bus.chk_addr2 = '0;

    // Reset state
    tick(); tick();
    check("rst_alu_ready", 32'(bus.alu_ready), 0);
    check("rst_mem_ready", 32'(bus.mem_ready), 0);
    check("rst_wb_en",     32'(bus.wb_en),     0);
    check("rst_wb_addr",   32'(bus.wb_addr),   0);
    check("rst_wb_data",   32'(bus.wb_data),   0);
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", 32'(bus.alu_ready), 1);
    check("post_rst_mem_ready", 32'(bus.mem_ready), 1);
    check("post_rst_pend1",     32'(bus.pend1),     0);
    check("post_rst_pend2",     32'(bus.pend2),     0);

    // Single ALU write: accepted at edge 0, on wb_* after edge 1 only
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 16'hBEEF;
    bus.chk_addr1 = 4'd3;
    #1;
    check("single_pend1_before", 32'(bus.pend1), 0);
    tick();
    bus.alu_valid = 1'b0;
    check("single_e0_wb_en", 32'(bus.wb_en), 0);
    check("single_e0_pend1", 32'(bus.pend1), 1);
    tick();
    check("single_e1_wb_en",   32'(bus.wb_en),   1);
    check("single_e1_wb_addr", 32'(bus.wb_addr), 3);
    check("single_e1_wb_data", 32'(bus.wb_data), 32'hBEEF);
    check("single_e1_pend1",   32'(bus.pend1),   1);
    tick();
    check("single_e2_wb_en",   32'(bus.wb_en),   0);
    check("single_e2_wb_addr", 32'(bus.wb_addr), 3);
    check("single_e2_pend1",   32'(bus.pend1),   0);

    // Collision with starvation relief
    run_stream(8, 1, 7, 9, 15, 60);
    check_log("coll", 15, exp_coll, 8);

    // ALU backpressure behind mem traffic
    run_stream(3, 1, 6, 10, 9, 60);
    check("bp_alu_ready_after2", 32'(alu_rdy_after2), 0);
    check_log("bp", 9, exp_bp, 3);

    // Pointer wrap on mem alone
    run_stream(0, 0, 10, 0, 10, 60);
    check("wrap_mem_ready_high", 32'(mem_rdy_always), 1);
    check("wrap_one_per_cycle",  32'(last_cyc - first_cyc), 9);
    check_log("wrap", 10, exp_wrap, -1);

    // Pending detection: in-flight wb to 7, queued mem write to 5
    tick();
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd7; bus.mem_data = 16'h0707;
    tick();
    bus.mem_addr = 4'd5; bus.mem_data = 16'h0505;
    tick();
    bus.mem_valid = 1'b0;
    check("pend_setup_wb_addr", 32'(bus.wb_addr), 7);
    bus.chk_addr2 = 4'd5; #1;
    check("pend2_queued_5", 32'(bus.pend2), 1);
    bus.chk_addr2 = 4'd7; #1;
    check("pend2_inflight_7", 32'(bus.pend2), 1);
    bus.chk_addr2 = 4'd6; #1;
    check("pend2_none_6", 32'(bus.pend2), 0);
    bus.chk_addr2 = 4'd5;
    tick();
    check("pend2_5_on_wb", 32'(bus.pend2), 1);
    tick();
    check("pend2_5_captured", 32'(bus.pend2), 0);

    // Reset mid-operation discards queued entries
    bus.chk_addr1 = 4'd4; bus.chk_addr2 = 4'd5;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = 16'h4444;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd5; bus.mem_data = 16'h5555;
    repeat (6) tick();
    check("midrst_pend1_before", 32'(bus.pend1), 1);
    check("midrst_pend2_before", 32'(bus.pend2), 1);
    rst = 1'b1; #1;
    check("midrst_alu_ready", 32'(bus.alu_ready), 0);
    check("midrst_mem_ready", 32'(bus.mem_ready), 0);
    tick();
    check("midrst_wb_en",   32'(bus.wb_en),   0);
    check("midrst_wb_addr", 32'(bus.wb_addr), 0);
    rst = 1'b0;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    saw_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wb_en) saw_wb = 1'b1;
    end
    check("midrst_no_stale_wb", 32'(saw_wb),    0);
    check("midrst_pend1_after", 32'(bus.pend1), 0);
    check("midrst_pend2_after", 32'(bus.pend2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
